fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage that feeds the single-cycle core.
//  - Generates sequential PCs and issues word requests to an instruction memory over a valid/ready port.
//  - Buffers in-order responses in a small prefetch FIFO.
//  - Presents {pc, instr} to the core over a valid/ready handshake.
//  - Redirects (branch/jump/trap) flush the buffer and discard in-flight responses.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of the first fetch after reset
//  DEPTH     2              prefetch FIFO entries (power of 2, >=2); also caps outstanding requests
// PORTS
//  clk             in   1   sole clock, all state on rising edge
//  reset           in   1   synchronous, active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   response valid; in request order, never back-pressured
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   flush and restart fetch at redirect_pc
//  redirect_pc     in   32  new PC; bits[1:0] are ignored (forced 0)
//  instr_valid     out  1   head entry valid toward core
//  instr_ready     in   1   core consumes head entry
//  instr_pc        out  32  PC of head entry
//  instr_data      out  32  instruction word of head entry
// BEHAVIOUR
//  - Reset (reset==0 at edge) sets:
//    - fetch_pc=RESET_PC; outstanding=0; drop_cnt=0; FIFO empty.
//    - Outputs: instr_valid=0, imem_req_valid=0.
//    - reset mid-operation discards everything; responses to pre-reset requests are not the unit's concern.
//  - Credit: imem_req_valid = (fifo_count + outstanding < DEPTH) && !redirect_valid. imem_req_addr = fetch_pc.
//  - Accept (valid & ready):
//    - fetch_pc += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
//    - Requested PC is pushed to an internal pc-tag queue.
//  - Request stability: once asserted, valid/addr hold until accepted. Sole exception: a redirect cycle, which withdraws valid.
//  - Response:
//    - If drop_cnt!=0: discard, drop_cnt--.
//    - Else: push {tag_pc, data} into FIFO.
//    - In both cases outstanding-- and the tag is popped.
//    - Response-in to instr_valid latency = 1 cycle (no bypass).
//  - First request is issued in the first cycle after reset is released. Minimum fetch-to-instr_valid latency = memory latency + 1.
//  - Output handshake:
//    - instr_valid = FIFO non-empty.
//    - instr_pc/instr_data are the head entry, stable while valid & !ready.
//    - Pop on instr_valid & instr_ready.
//  - Redirect (highest priority):
//    - FIFO cleared; fetch_pc = {redirect_pc[31:2],2'b00}.
//    - drop_cnt = outstanding after this cycle's response, i.e. outstanding - rsp (rsp = 1 if imem_rsp_valid this cycle, else 0).
//    - No request is accepted on a redirect cycle.
//    - A response arriving in the redirect cycle is discarded.
//    - A core pop in the redirect cycle is harmless.
//  - Back-to-back redirects: each re-arms drop_cnt from the current outstanding count. The last redirect_pc wins.
//  - FSM:
//    - RUN: drop_cnt==0.
//    - FLUSH: drop_cnt>0; requests to the new PC may issue if credit allows.
//    - RUN->FLUSH on a redirect with outstanding after this cycle's response >0.
//    - FLUSH->RUN when the last stale response is dropped.
//  - Full FIFO plus DEPTH outstanding cannot occur: credit rule guarantees space for every response.
//  - Simultaneous push and pop on a full FIFO is legal (count unchanged).
// STRUCTURE
//  - Package fetch_pkg:
//    - XLEN=32, INSTR_BYTES=4, RESET_PC default.
//    - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
//    - typedef enum logic {RUN, FLUSH} fetch_state_t.
//  - One sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH entries.
//    - Ports: push, pop, flush, full, empty, count. Also reused as the pc-tag queue.
// TESTING
//  1. Reset release, 1-cycle memory, instr_ready=1 -> PCs 0x0,0x4,0x8... each instr_data matches mem[pc>>2], one per cycle steady state.
//  2. instr_ready=0 for 10 cycles -> exactly DEPTH entries buffered, imem_req_valid=0. Release -> entries in order, no gap, no loss.
//  3. 3-cycle memory latency, redirect to 0x103 with 2 outstanding -> both stale responses dropped; first instr_pc=0x100.
//  4. redirect with simultaneous imem_rsp_valid and instr_ready -> response discarded, FIFO empty next cycle, fetch resumes at new PC.
//  5. RESET_PC=32'hFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//  6. reset asserted mid-stream with 2 buffered and 1 outstanding -> next cycle instr_valid=0, imem_req_valid=0. After release, fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// fetch_entry_t is what the core sees: the PC and the instruction word fetched from it.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Clears the byte-offset bits so that a PC points at a whole word.
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN,
        FLUSH
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO.
// The fetch unit uses it twice: as the prefetch buffer, and as the queue of PCs that are still waiting for a response.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = $bits(fetch_entry_t),
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem_reg[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches, buffers responses in order, and hands {pc, instr} to the core.
// A redirect flushes the buffer and drops the responses that were still in flight when it arrived.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    fetch_state_t    state_reg, state_next;

    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   outstanding;
    logic [CW:0]     credit_used;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic            tag_full, tag_empty, tag_pop;
    logic            req_fire;
    fetch_entry_t    fifo_wdata, fifo_rdata;
    logic [XLEN-1:0] tag_pc;

    // Every request already holds a slot in the buffer, so a response can always be stored.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = reset && !redirect_valid && !fifo_full && !tag_full
                            && (credit_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign tag_pop    = imem_rsp_valid && !tag_empty;
    assign fifo_pop   = !fifo_empty && instr_ready;
    assign fifo_wdata = '{pc: tag_pc, instr: imem_rsp_data};

    assign instr_valid = !fifo_empty;
    assign instr_pc    = fifo_rdata.pc;
    assign instr_data  = fifo_rdata.instr;

    // PCs of requests still awaiting a response; the count is the outstanding-request count.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .pop   (tag_pop),
        .flush (1'b0),
        .wdata (fetch_pc_reg),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (outstanding)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_reg <= RESET_PC;
            drop_cnt_reg <= '0;
            state_reg    <= RUN;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            drop_cnt_reg <= drop_cnt_next;
            state_reg    <= state_next;
        end
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        drop_cnt_next = drop_cnt_reg;
        state_next    = state_reg;
        fifo_push     = 1'b0;

        if (redirect_valid) begin
            // Everything still in flight after this cycle's response belongs to the old path.
            fetch_pc_next = redirect_pc & PC_ALIGN_MASK;
            drop_cnt_next = outstanding - CW'(imem_rsp_valid);
            state_next    = (drop_cnt_next != '0) ? FLUSH : RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + XLEN'(INSTR_BYTES);
            end
            case (state_reg)
                RUN: begin
                    fifo_push = imem_rsp_valid;
                end
                FLUSH: begin
                    if (imem_rsp_valid) begin
                        drop_cnt_next = drop_cnt_reg - CW'(1);
                        if (drop_cnt_reg == CW'(1)) begin
                            state_next = RUN;
                        end
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc, instr} pairs,
// and a monitor checks every core handshake against them.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_pc, instr_data;

    logic        d2_req_valid, d2_req_ready, d2_rsp_valid, d2_redirect_valid, d2_instr_valid, d2_instr_ready;
    logic [31:0] d2_req_addr, d2_rsp_data, d2_redirect_pc, d2_instr_pc, d2_instr_data;

    int          checks = 0;
    int          errors = 0;
    int          pop_count = 0;
    int          acc_count = 0;
    int          cyc = 0;
    int          lat = 1;
    exp_t        exp_q[$];
    logic [31:0] exp2_q[$];
    pend_t       pend_q[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc), .instr_data(instr_data)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset2),
        .imem_req_valid(d2_req_valid), .imem_req_ready(d2_req_ready), .imem_req_addr(d2_req_addr),
        .imem_rsp_valid(d2_rsp_valid), .imem_rsp_data(d2_rsp_data),
        .redirect_valid(d2_redirect_valid), .redirect_pc(d2_redirect_pc),
        .instr_valid(d2_instr_valid), .instr_ready(d2_instr_ready), .instr_pc(d2_instr_pc), .instr_data(d2_instr_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: start + 32'(4 * i), data: mem_word(start + 32'(4 * i))});
        end
    endtask

    // Memory model: in-order responses, 'lat' cycles after acceptance.
    logic        mem_acc, mem_rst;
    logic [31:0] mem_addr;
    pend_t       mem_p;
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            mem_acc  = reset && imem_req_valid && imem_req_ready;
            mem_addr = imem_req_addr;
            mem_rst  = !reset;
            @(posedge clk);
            #1;
            cyc++;
            if (mem_rst) begin
                pend_q.delete();
            end else if (mem_acc) begin
                acc_count++;
                pend_q.push_back('{addr: mem_addr, due: cyc + lat - 1});
            end
            if (!mem_rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mem_p          = pend_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_p.addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (reset && !redirect_valid && instr_valid && instr_ready) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: unexpected entry pc=%h required=none", instr_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("instr pc=%h data=%h", instr_pc, instr_data);
                    check("instr_pc", instr_pc, mon_e.pc);
                    check("instr_data", instr_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset2 && d2_req_valid && d2_req_ready) begin
                if (exp2_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wrap_req: unexpected addr=%h required=none", d2_req_addr);
                end else begin
                    $display("wrap req addr=%h", d2_req_addr);
                    check("wrap_req_addr", d2_req_addr, exp2_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int   p0;
    logic found;
    initial begin
        reset = 1'b0; reset2 = 1'b0;
        imem_req_ready = 1'b1; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        d2_req_ready = 1'b1; d2_rsp_valid = 1'b0; d2_rsp_data = '0;
        d2_redirect_valid = 1'b0; d2_redirect_pc = '0; d2_instr_ready = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_wrap_req_valid", 32'(d2_req_valid), 0);

        // 1: sequential stream, 1-cycle memory, core always ready
        push_stream(32'h0, 128);
        exp2_q.push_back(32'hFFFF_FFF8);
        exp2_q.push_back(32'hFFFF_FFFC);
        exp2_q.push_back(32'h0000_0000);
        exp2_q.push_back(32'h0000_0004);
        tick(1);
        reset = 1'b1; reset2 = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 1);
        check("first_req_addr", imem_req_addr, 32'h0);
        tick(9);
        p0 = pop_count;
        tick(20);
        check("t1_one_per_cycle", 32'(pop_count - p0), 20);

        // 2: core stalls, buffer fills to DEPTH, then drains without gaps
        instr_ready = 1'b0;
        tick(10);
        @(negedge clk);
        check("t2_req_valid", 32'(imem_req_valid), 0);
        check("t2_instr_valid", 32'(instr_valid), 1);
        check("t2_buffered", 32'(acc_count - pop_count), DEPTH);
        check("t2_in_flight", 32'(pend_q.size()), 0);
        tick(1);
        instr_ready = 1'b1;
        p0 = pop_count;
        tick(8);
        check("t2_drain_no_gap", 32'(pop_count - p0), 8);

        // 3: two stale requests in flight on a 3-cycle memory, redirect to 0x103
        instr_ready = 1'b0; imem_req_ready = 1'b0;
        tick(4);
        redirect_valid = 1'b1; redirect_pc = 32'h40; exp_q.delete(); lat = 3;
        tick(1);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        tick(2);
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick(1);
        redirect_valid = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        push_stream(32'h100, 64);
        @(negedge clk);
        check("t3_req_valid", 32'(imem_req_valid), 1);
        check("t3_req_addr", imem_req_addr, 32'h100);
        tick(20);
        check("t3_progress", 32'((64 - exp_q.size()) >= 8), 1);

        // 4: redirect in a cycle with both a response and a core pop
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick(1);
            found = imem_rsp_valid && instr_valid;
        end
        check("t4_overlap_found", 32'(found), 1);
        redirect_valid = 1'b1; redirect_pc = 32'h200; exp_q.delete();
        tick(1);
        redirect_valid = 1'b0;
        push_stream(32'h200, 64);
        @(negedge clk);
        check("t4_fifo_empty", 32'(instr_valid), 0);
        check("t4_req_valid", 32'(imem_req_valid), 1);
        check("t4_req_addr", imem_req_addr, 32'h200);
        tick(20);
        check("t4_progress", 32'((64 - exp_q.size()) >= 8), 1);

        // 6: reset with two entries buffered and one request outstanding
        instr_ready = 1'b0; imem_req_ready = 1'b0;
        tick(6);
        redirect_valid = 1'b1; redirect_pc = 32'h300; exp_q.delete();
        tick(1);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        tick(3);
        imem_req_ready = 1'b0;
        tick(2);
        @(negedge clk);
        check("t6_buffered_before_reset", 32'(instr_valid), 1);
        tick(1);
        reset = 1'b0;
        tick(1);
        @(negedge clk);
        check("t6_instr_valid", 32'(instr_valid), 0);
        check("t6_req_valid", 32'(imem_req_valid), 0);
        tick(1);
        reset = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        push_stream(32'h0, 64);
        @(negedge clk);
        check("t6_restart_valid", 32'(imem_req_valid), 1);
        check("t6_restart_addr", imem_req_addr, 32'h0);
        tick(20);
        check("t6_progress", 32'((64 - exp_q.size()) >= 8), 1);

        // 5: RESET_PC near the top of the address space wraps to zero
        check("t5_all_addrs_seen", 32'(exp2_q.size()), 0);
        check("t5_credit_stall", 32'(d2_req_valid), 0);
        check("t5_no_instr", 32'(d2_instr_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
